// File: rtl/sram_bank_ctrl_pkg.sv
// Shared types and constants for the SRAM bank controller.
//   state_e    : controller FSM states
//   MaxBanks   : largest supported bank count
//   LenW       : width of the burst length field (beats-1)
//   bank_width : bank-select width for a given bank count (never below 1)
package sram_bank_ctrl_pkg;

  localparam int unsigned MaxBanks = 16;
  localparam int unsigned LenW     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StCapture,
    StResp
  } state_e;

  function automatic int unsigned bank_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_bank_rdmux.sv
// Read-data multiplexer: selects one macro's dout slice by bank number.
// Ports:
//   bank  - bank index; indices >= NUM_BANKS select zero
//   dout  - concatenated macro outputs, bank b at [b*DATA_W +: DATA_W]
//   rdata - selected word
module sram_bank_rdmux
  import sram_bank_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_BANKS = 4,
  localparam int unsigned BANK_W   = bank_width(NUM_BANKS)
) (
  input  logic [BANK_W-1:0]           bank,
  input  logic [NUM_BANKS*DATA_W-1:0] dout,
  output logic [DATA_W-1:0]           rdata
);

  always_comb begin
    rdata = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank == BANK_W'(b)) begin
        rdata = dout[b*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Front-end for NUM_BANKS single-port SRAM macros sharing web/addr/din and
// selected by a per-bank active-low chip select. One valid/ready request
// port, one valid/ready response port, one request outstanding at a time.
//
// Optional feature (macro SRAM_BANK_CTRL_BURST_EN): adds req_len (beats-1);
// reads become sequential bursts across banks, wrapping at the top of the
// flat address space. Burst writes (req_len != 0) are rejected with an error.
//
// Ports:
//   wb_clk_i, wb_rst_i     - clock and synchronous active-high reset
//   req_valid/req_ready    - request handshake
//   req_we, req_addr       - write flag, {bank, word} address
//   req_wdata              - write data
//   req_len                - burst length minus one (burst build only)
//   rsp_valid/rsp_ready    - response handshake
//   rsp_rdata, rsp_err     - read data (0 for writes/errors), range error
//   busy                   - controller not idle
//   sram_csb/web/addr/din  - registered macro pins
//   sram_dout              - concatenated macro outputs
module sram_bank_ctrl
  import sram_bank_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned NUM_BANKS = 4,
  localparam int unsigned BANK_W   = bank_width(NUM_BANKS)
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [BANK_W+ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
`ifdef SRAM_BANK_CTRL_BURST_EN
  input  logic [LenW-1:0]             req_len,
`endif
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [NUM_BANKS-1:0]        sram_csb,
  output logic                        sram_web,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_din,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout
);

  localparam int unsigned AW = BANK_W + ADDR_W;
  // Highest legal flat address; burst increments wrap to zero after it.
  localparam logic [AW-1:0] LastAddr = AW'((NUM_BANKS << ADDR_W) - 1);

  if (NUM_BANKS < 1 || NUM_BANKS > MaxBanks) begin : g_bad_cfg
    $error("sram_bank_ctrl: NUM_BANKS out of supported range");
  end

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a[AW-1 -: BANK_W]) < NUM_BANKS;
  endfunction

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [NUM_BANKS-1:0] csb_q, csb_d;
  logic                web_q, web_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   din_q, din_d;

  logic                start;
  logic [AW-1:0]       start_addr;
  logic                start_we;
  logic [DATA_W-1:0]   start_wdata;
  logic                bad_len;
  logic [AW-1:0]       next_addr;
  logic [DATA_W-1:0]   mux_rdata;

  sram_bank_rdmux #(
    .DATA_W   (DATA_W),
    .NUM_BANKS(NUM_BANKS)
  ) u_rdmux (
    .bank (addr_q[AW-1 -: BANK_W]),
    .dout (sram_dout),
    .rdata(mux_rdata)
  );

  assign next_addr = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    csb_d       = '1;
    web_d       = 1'b1;
    maddr_d     = maddr_q;
    din_d       = din_q;
    start       = 1'b0;
    start_addr  = addr_q;
    start_we    = we_q;
    start_wdata = wdata_q;
    bad_len     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          start       = 1'b1;
          start_addr  = req_addr;
          start_we    = req_we;
          start_wdata = req_wdata;
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
`ifdef SRAM_BANK_CTRL_BURST_EN
          len_d       = req_len;
          bad_len     = req_we && (req_len != '0);
`else
          len_d       = '0;
`endif
        end
      end
      StAccess: begin
        state_d = we_q ? StResp : StCapture;
      end
      StCapture: begin
        rdata_d = mux_rdata;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StIdle;
          // Remaining burst beats go straight to the next access.
          if (!err_q && !we_q && len_q != '0) begin
            start      = 1'b1;
            start_addr = next_addr;
            addr_d     = next_addr;
            len_d      = len_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Common beat launch: either reject with an error or drive the pins
    // for a one-cycle access to the selected bank.
    if (start) begin
      rdata_d = '0;
      if (!in_range(start_addr) || bad_len) begin
        err_d   = 1'b1;
        state_d = StResp;
      end else begin
        err_d   = 1'b0;
        state_d = StAccess;
        csb_d   = ~(NUM_BANKS'(1) << start_addr[AW-1 -: BANK_W]);
        web_d   = ~start_we;
        maddr_d = start_addr[ADDR_W-1:0];
        din_d   = start_wdata;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      csb_q   <= '1;
      web_q   <= 1'b1;
      maddr_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      maddr_q <= maddr_d;
      din_q   <= din_d;
    end
  end

  assign req_ready = (state_q == StIdle) & ~wb_rst_i;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign sram_csb  = csb_q;
  assign sram_web  = web_q;
  assign sram_addr = maddr_q;
  assign sram_din  = din_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: a 4-bank instance and a 3-bank instance share
// stimulus; sel chooses which one receives req_valid and is observed.
module tb_sram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic [3:0]  req_len;

  logic        req_ready4, rsp_valid4, rsp_err4, busy4, web4;
  logic [7:0]  rsp_rdata4, din4;
  logic [3:0]  csb4;
  logic [9:0]  maddr4;
  logic [31:0] dout4;

  logic        req_ready3, rsp_valid3, rsp_err3, busy3, web3;
  logic [7:0]  rsp_rdata3, din3;
  logic [2:0]  csb3;
  logic [9:0]  maddr3;
  logic [23:0] dout3;

  logic [7:0]  mem4 [0:3][0:1023];
  logic [7:0]  mem3 [0:2][0:1023];

  always #5 clk = ~clk;

  sram_bank_ctrl #(.DATA_W(8), .ADDR_W(10), .NUM_BANKS(4)) u_dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid & ~sel), .req_ready(req_ready4), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_BANK_CTRL_BURST_EN
    .req_len(req_len),
`endif
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4),
    .rsp_err(rsp_err4), .busy(busy4), .sram_csb(csb4), .sram_web(web4),
    .sram_addr(maddr4), .sram_din(din4), .sram_dout(dout4)
  );

  sram_bank_ctrl #(.DATA_W(8), .ADDR_W(10), .NUM_BANKS(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid & sel), .req_ready(req_ready3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_BANK_CTRL_BURST_EN
    .req_len(req_len),
`endif
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .busy(busy3), .sram_csb(csb3), .sram_web(web3),
    .sram_addr(maddr3), .sram_din(din3), .sram_dout(dout3)
  );

  // Behavioural macros: registered read, write on the clock edge.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 1024; a++) mem4[b][a] <= 8'h00;
      for (int b = 0; b < 3; b++)
        for (int a = 0; a < 1024; a++) mem3[b][a] <= 8'h00;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!csb4[b]) begin
          if (!web4) mem4[b][maddr4] <= din4;
          else       dout4[b*8 +: 8] <= mem4[b][maddr4];
        end
      end
      for (int b = 0; b < 3; b++) begin
        if (!csb3[b]) begin
          if (!web3) mem3[b][maddr3] <= din3;
          else       dout3[b*8 +: 8] <= mem3[b][maddr3];
        end
      end
    end
  end

  logic       req_ready, rsp_valid, rsp_err, busy, sram_web;
  logic [7:0] rsp_rdata, sram_din;
  logic [3:0] sram_csb;
  logic [9:0] sram_addr;

  assign req_ready = sel ? req_ready3 : req_ready4;
  assign rsp_valid = sel ? rsp_valid3 : rsp_valid4;
  assign rsp_err   = sel ? rsp_err3   : rsp_err4;
  assign rsp_rdata = sel ? rsp_rdata3 : rsp_rdata4;
  assign busy      = sel ? busy3      : busy4;
  assign sram_csb  = sel ? {1'b1, csb3} : csb4;
  assign sram_web  = sel ? web3       : web4;
  assign sram_addr = sel ? maddr3     : maddr4;
  assign sram_din  = sel ? din3       : din4;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One request with rsp_ready high. lat counts cycles from the handshake
  // edge to the edge at which rsp_valid is taken.
  task automatic txn(input logic we, input logic [11:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic er, output int lat,
                     output logic [3:0] csb_and, output logic web_and);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; csb_and = 4'hF; web_and = 1'b1;
    while (!rsp_valid && lat < 20) begin
      csb_and = csb_and & sram_csb;
      web_and = web_and & sram_web;
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       sel;
    logic       we;
    logic [11:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         lat;
    logic [3:0] csb;
    logic       web;
  } vec_t;

  vec_t vecs [14];

  logic [7:0] got_q [$];
  logic [3:0] csbs_q [$];
  logic       errs_q [$];

  // Burst read with rsp_ready high, recording each response and the chip
  // select seen during the access that produced it.
  task automatic burst_rd(input logic [11:0] addr, input logic [3:0] len);
    logic [3:0] last_csb = 4'hF;
    got_q.delete(); csbs_q.delete(); errs_q.delete();
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_len = 4'd0;
    for (int c = 0; c < 40; c++) begin
      if (sram_csb != 4'hF) last_csb = sram_csb;
      if (rsp_valid) begin
        got_q.push_back(rsp_rdata);
        errs_q.push_back(rsp_err);
        csbs_q.push_back(last_csb);
        last_csb = 4'hF;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] rd;
  logic       er, wb;
  int         lat;
  logic [3:0] cs;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 12'h005, 8'hA5, 8'h00, 1'b0, 2, 4'b1110, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 12'h005, 8'h00, 8'hA5, 1'b0, 3, 4'b1110, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 12'hFFF, 8'h5A, 8'h00, 1'b0, 2, 4'b0111, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 12'h3FF, 8'h11, 8'h00, 1'b0, 2, 4'b1110, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 12'hFFF, 8'h00, 8'h5A, 1'b0, 3, 4'b0111, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 12'h3FF, 8'h00, 8'h11, 1'b0, 3, 4'b1110, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 12'h005, 8'h00, 8'hA5, 1'b0, 3, 4'b1110, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 12'h923, 8'hC3, 8'h00, 1'b0, 2, 4'b1011, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 12'h523, 8'h00, 8'h00, 1'b0, 3, 4'b1101, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 12'h923, 8'h00, 8'hC3, 1'b0, 3, 4'b1011, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 12'hC00, 8'h00, 8'h00, 1'b1, 1, 4'b1111, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 12'h810, 8'h77, 8'h00, 1'b0, 2, 4'b1011, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 12'h810, 8'h00, 8'h77, 1'b0, 3, 4'b1011, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 12'hC01, 8'h99, 8'h00, 1'b1, 1, 4'b1111, 1'b1};

    rst = 1'b1; mem_clr = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;

    // Reset state
    chk("rst req_ready", req_ready, 0);
    chk("rst csb", sram_csb, 4'hF);
    chk("rst web", sram_web, 1);
    chk("rst addr", sram_addr, 0);
    chk("rst din", sram_din, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rdata", rsp_rdata, 0);
    chk("rst err", rsp_err, 0);
    chk("rst busy", busy, 0);
    chk("rst csb3", csb3, 3'b111);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst req_ready", req_ready, 1);

    // Table-driven single transactions
    for (int i = 0; i < 14; i++) begin
      sel = vecs[i].sel;
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat, cs, wb);
      chk($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d err", i), er, vecs[i].err);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d csb", i), cs, vecs[i].csb);
      chk($sformatf("v%0d web", i), wb, vecs[i].web);
    end
    sel = 1'b0;

    // Backpressure: response held for 5 cycles
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h005; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp latency", lat + 1, 3);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d valid", c), rsp_valid, 1);
      chk($sformatf("bp%0d rdata", c), rsp_rdata, 8'hA5);
      chk($sformatf("bp%0d req_ready", c), req_ready, 0);
      chk($sformatf("bp%0d csb", c), sram_csb, 4'hF);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp done valid", rsp_valid, 0);
    chk("bp done req_ready", req_ready, 1);

    // Reset during CAPTURE
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'hFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid csb access", sram_csb, 4'b0111);
    @(posedge clk); #1;
    chk("mid busy capture", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid rst csb", sram_csb, 4'hF);
    chk("mid rst web", sram_web, 1);
    chk("mid rst addr", sram_addr, 0);
    chk("mid rst din", sram_din, 0);
    chk("mid rst valid", rsp_valid, 0);
    chk("mid rst rdata", rsp_rdata, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst req_ready", req_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid post req_ready", req_ready, 1);
    chk("mid post valid", rsp_valid, 0);
    txn(1'b0, 12'hFFF, 8'h00, rd, er, lat, cs, wb);
    chk("mid reread", rd, 8'h5A);

`ifdef SRAM_BANK_CTRL_BURST_EN
    txn(1'b1, 12'h3FE, 8'h01, rd, er, lat, cs, wb);
    txn(1'b1, 12'h3FF, 8'h02, rd, er, lat, cs, wb);
    txn(1'b1, 12'h400, 8'h03, rd, er, lat, cs, wb);
    txn(1'b1, 12'h000, 8'h42, rd, er, lat, cs, wb);

    burst_rd(12'h3FE, 4'd2);
    chk("burst count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("burst d0", got_q[0], 8'h01);
      chk("burst d1", got_q[1], 8'h02);
      chk("burst d2", got_q[2], 8'h03);
      chk("burst csb0", csbs_q[0], 4'b1110);
      chk("burst csb1", csbs_q[1], 4'b1110);
      chk("burst csb2", csbs_q[2], 4'b1101);
      chk("burst err2", errs_q[2], 0);
    end

    burst_rd(12'hFFF, 4'd1);
    chk("wrap count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("wrap d0", got_q[0], 8'h5A);
      chk("wrap d1", got_q[1], 8'h42);
      chk("wrap csb1", csbs_q[1], 4'b1110);
    end

    req_len = 4'd1;
    txn(1'b1, 12'h010, 8'hEE, rd, er, lat, cs, wb);
    req_len = 4'd0;
    chk("blen err", er, 1);
    chk("blen latency", lat, 1);
    chk("blen csb", cs, 4'hF);
    txn(1'b0, 12'h010, 8'h00, rd, er, lat, cs, wb);
    chk("blen no write", rd, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
